// File: rtl/axi4_lite_ctrl_master_pkg.sv
// Shared definitions for the AXI4-Lite control master: response codes and
// FSM state encodings (also used by the control slave and command handler).
package axi4_lite_ctrl_master_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5,
        ST_DRAIN   = 3'd6
    } state_e;

endpackage

// File: rtl/axi4_lite_ctrl_master_timeout_counter.sv
// Response watchdog for the AXI4-Lite control master. Down-counter loaded on
// clear; hit is raised while enabled and the count has reached zero.
// Only built when AXI_CTRL_MASTER_TIMEOUT_EN is defined.
`ifdef AXI_CTRL_MASTER_TIMEOUT_EN
module axi4_lite_timeout_counter #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LOAD = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Reload on clear, otherwise count down while enabled and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = enable && (cnt_q == '0);

endmodule
`endif

// File: rtl/axi4_lite_ctrl_master.sv
// AXI4-Lite initiator: one outstanding single-beat read or write, driven from
// a local command port, result returned on a response port.
// Optional watchdog: AXI_CTRL_MASTER_TIMEOUT_EN.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  IDLE       | cmd_ready high, waiting for a command
//  WR_REQ     | AW and W valids outstanding
//  WR_RESP    | bready high, waiting for B
//  RD_REQ     | arvalid high, waiting for arready
//  RD_DATA    | rready high, waiting for R
//  RSP        | rsp_valid held until rsp_ready
//  DRAIN      | after a timeout, finish the late handshakes and discard them
//
// Handshake bookkeeping for AW/W/B/AR/R is independent of state, so a timed
// out transaction keeps completing on the bus while the FSM reports it.
module axi4_lite_ctrl_master
    import axi4_lite_ctrl_master_pkg::*;
#(
    parameter int AXI_ADDRESS_WIDTH = 32,
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                         m_axi_ctrl_aclk,
    input  logic                         m_axi_ctrl_aresetn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [AXI_ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]    cmd_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_write,
    output logic [AXI_DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]                   rsp_resp,
    output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_ctrl_awaddr,
    output logic                         m_axi_ctrl_awvalid,
    input  logic                         m_axi_ctrl_awready,
    output logic [AXI_DATA_WIDTH-1:0]    m_axi_ctrl_wdata,
    output logic                         m_axi_ctrl_wvalid,
    input  logic                         m_axi_ctrl_wready,
    input  logic [1:0]                   m_axi_ctrl_bresp,
    input  logic                         m_axi_ctrl_bvalid,
    output logic                         m_axi_ctrl_bready,
    output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_ctrl_araddr,
    output logic                         m_axi_ctrl_arvalid,
    input  logic                         m_axi_ctrl_arready,
    input  logic [AXI_DATA_WIDTH-1:0]    m_axi_ctrl_rdata,
    input  logic [1:0]                   m_axi_ctrl_rresp,
    input  logic                         m_axi_ctrl_rvalid,
    output logic                         m_axi_ctrl_rready
);

    state_e state_q, state_d;

    logic                         awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                         bready_q, bready_d, arvalid_q, arvalid_d;
    logic                         rready_q, rready_d;
    logic [AXI_ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [AXI_DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                         rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic [AXI_DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                   rsp_resp_q, rsp_resp_d;

    logic cmd_hs, ar_hs, b_hs, r_hs, rsp_hs;
    logic aw_fin, w_fin, wr_req_done, bus_idle;
    logic to_hit, drain_needed;

    assign cmd_ready   = (state_q == ST_IDLE);
    assign cmd_hs      = cmd_valid && cmd_ready;
    assign ar_hs       = arvalid_q && m_axi_ctrl_arready;
    assign b_hs        = bready_q && m_axi_ctrl_bvalid;
    assign r_hs        = rready_q && m_axi_ctrl_rvalid;
    assign rsp_hs      = rsp_valid_q && rsp_ready;
    // No AW (resp. W) left outstanding after this cycle.
    assign aw_fin      = !awvalid_q || m_axi_ctrl_awready;
    assign w_fin       = !wvalid_q || m_axi_ctrl_wready;
    assign wr_req_done = (awvalid_q || wvalid_q) && aw_fin && w_fin;
    assign bus_idle    = !(awvalid_q || wvalid_q || bready_q || arvalid_q || rready_q);

`ifdef AXI_CTRL_MASTER_TIMEOUT_EN
    logic timed_out_q, timed_out_d;
    logic to_enable, to_clear;

    assign to_enable = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                       (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
    assign to_clear  = (state_d != state_q);

    axi4_lite_timeout_counter #(
        .LIMIT  (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (m_axi_ctrl_aclk),
        .rst_n  (m_axi_ctrl_aresetn),
        .clear  (to_clear),
        .enable (to_enable),
        .hit    (to_hit)
    );

    // Remember that the pending response was synthesised by the watchdog.
    always_comb begin
        timed_out_d = timed_out_q;
        if (to_hit && (state_d == ST_RSP) && (state_q != ST_RSP)) begin
            timed_out_d = 1'b1;
        end else if ((state_q == ST_RSP) && rsp_hs) begin
            timed_out_d = 1'b0;
        end
    end

    // Timeout flag register.
    always_ff @(posedge m_axi_ctrl_aclk or negedge m_axi_ctrl_aresetn) begin
        if (!m_axi_ctrl_aresetn) begin
            timed_out_q <= 1'b0;
        end else begin
            timed_out_q <= timed_out_d;
        end
    end

    assign drain_needed = timed_out_q;
`else
    // TIMEOUT_CYCLES has no effect without the watchdog.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign to_hit             = 1'b0;
    assign drain_needed       = 1'b0;
`endif

    // State register.
    always_ff @(posedge m_axi_ctrl_aclk or negedge m_axi_ctrl_aresetn) begin
        if (!m_axi_ctrl_aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; real progress on the bus takes precedence over a timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (cmd_hs) state_d = cmd_write ? ST_WR_REQ : ST_RD_REQ;
            ST_WR_REQ:  if (aw_fin && w_fin) state_d = ST_WR_RESP;
            ST_WR_RESP: if (b_hs) state_d = ST_RSP;
            ST_RD_REQ:  if (ar_hs) state_d = ST_RD_DATA;
            ST_RD_DATA: if (r_hs) state_d = ST_RSP;
            ST_RSP:     if (rsp_hs) state_d = drain_needed ? ST_DRAIN : ST_IDLE;
`ifdef AXI_CTRL_MASTER_TIMEOUT_EN
            ST_DRAIN:   if (bus_idle) state_d = ST_IDLE;
`endif
            default:    state_d = ST_IDLE;
        endcase
        if (to_hit && (state_d == state_q)) begin
            state_d = ST_RSP;
        end
    end

    // Output next-values: launch on accept, drop each valid/ready after its handshake.
    always_comb begin
        awvalid_d   = awvalid_q && !m_axi_ctrl_awready;
        wvalid_d    = wvalid_q && !m_axi_ctrl_wready;
        arvalid_d   = arvalid_q && !m_axi_ctrl_arready;
        bready_d    = bready_q ? !m_axi_ctrl_bvalid : wr_req_done;
        rready_d    = rready_q ? !m_axi_ctrl_rvalid : ar_hs;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        araddr_d    = araddr_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        if (cmd_hs) begin
            if (cmd_write) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                awaddr_d  = cmd_addr;
                wdata_d   = cmd_wdata;
            end else begin
                arvalid_d = 1'b1;
                araddr_d  = cmd_addr;
            end
        end
        if ((state_d == ST_RSP) && (state_q != ST_RSP)) begin
            rsp_valid_d = 1'b1;
            rsp_write_d = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP);
            rsp_rdata_d = '0;
            rsp_resp_d  = RESP_TIMEOUT;
            if ((state_q == ST_WR_RESP) && b_hs) begin
                rsp_resp_d = m_axi_ctrl_bresp;
            end else if ((state_q == ST_RD_DATA) && r_hs) begin
                rsp_rdata_d = m_axi_ctrl_rdata;
                rsp_resp_d  = m_axi_ctrl_rresp;
            end
        end
    end

    // Output registers; every bus and response output comes straight from a flop.
    always_ff @(posedge m_axi_ctrl_aclk or negedge m_axi_ctrl_aresetn) begin
        if (!m_axi_ctrl_aresetn) begin
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            araddr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            araddr_q    <= araddr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign m_axi_ctrl_awvalid = awvalid_q;
    assign m_axi_ctrl_wvalid  = wvalid_q;
    assign m_axi_ctrl_bready  = bready_q;
    assign m_axi_ctrl_arvalid = arvalid_q;
    assign m_axi_ctrl_rready  = rready_q;
    assign m_axi_ctrl_awaddr  = awaddr_q;
    assign m_axi_ctrl_wdata   = wdata_q;
    assign m_axi_ctrl_araddr  = araddr_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_write          = rsp_write_q;
    assign rsp_rdata          = rsp_rdata_q;
    assign rsp_resp           = rsp_resp_q;

endmodule

// File: tb/tb_axi4_lite_ctrl_master.sv
// Directed bench for axi4_lite_ctrl_master. The slave side is driven by hand
// in each step; outputs are sampled on the falling edge.
module tb_axi4_lite_ctrl_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi4_lite_ctrl_master #(
        .AXI_ADDRESS_WIDTH (32),
        .AXI_DATA_WIDTH    (32),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .m_axi_ctrl_aclk    (clk),
        .m_axi_ctrl_aresetn (rst_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_write          (cmd_write),
        .cmd_addr           (cmd_addr),
        .cmd_wdata          (cmd_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_write          (rsp_write),
        .rsp_rdata          (rsp_rdata),
        .rsp_resp           (rsp_resp),
        .m_axi_ctrl_awaddr  (awaddr),
        .m_axi_ctrl_awvalid (awvalid),
        .m_axi_ctrl_awready (awready),
        .m_axi_ctrl_wdata   (wdata),
        .m_axi_ctrl_wvalid  (wvalid),
        .m_axi_ctrl_wready  (wready),
        .m_axi_ctrl_bresp   (bresp),
        .m_axi_ctrl_bvalid  (bvalid),
        .m_axi_ctrl_bready  (bready),
        .m_axi_ctrl_araddr  (araddr),
        .m_axi_ctrl_arvalid (arvalid),
        .m_axi_ctrl_arready (arready),
        .m_axi_ctrl_rdata   (rdata),
        .m_axi_ctrl_rresp   (rresp),
        .m_axi_ctrl_rvalid  (rvalid),
        .m_axi_ctrl_rready  (rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        step();
        step();
        // reset state
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        step();
        chk("idle_cmd_ready", cmd_ready, 1);

        // write 0x10 <- 0xDEADBEEF, zero-wait slave
        awready = 1'b1; wready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0010; cmd_wdata = 32'hDEAD_BEEF;
        step();
        cmd_valid = 1'b0;
        chk("w1_awvalid", awvalid, 1);
        chk("w1_wvalid", wvalid, 1);
        chk("w1_awaddr", awaddr, 32'h0000_0010);
        chk("w1_wdata", wdata, 32'hDEAD_BEEF);
        chk("w1_cmd_ready", cmd_ready, 0);
        step();
        chk("w1_aw_drop", awvalid, 0);
        chk("w1_w_drop", wvalid, 0);
        chk("w1_bready", bready, 1);
        chk("w1_no_rsp_c2", rsp_valid, 0);
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        chk("w1_rsp_valid_c3", rsp_valid, 1);
        chk("w1_rsp_write", rsp_write, 1);
        chk("w1_rsp_resp", rsp_resp, 2'b00);
        chk("w1_rsp_rdata", rsp_rdata, 0);
        chk("w1_bready_drop", bready, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("w1_rsp_done", rsp_valid, 0);
        chk("w1_back_idle", cmd_ready, 1);

        // write with awready three cycles late, wready immediate
        awready = 1'b0; wready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0020; cmd_wdata = 32'h0BAD_F00D;
        step();
        cmd_valid = 1'b0;
        chk("w2_awvalid_c1", awvalid, 1);
        chk("w2_wvalid_c1", wvalid, 1);
        step();
        chk("w2_wvalid_first_drop", wvalid, 0);
        chk("w2_awvalid_held_c2", awvalid, 1);
        chk("w2_no_bready_c2", bready, 0);
        step();
        chk("w2_awvalid_held_c3", awvalid, 1);
        chk("w2_awaddr_stable", awaddr, 32'h0000_0020);
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("w2_awvalid_drop", awvalid, 0);
        chk("w2_bready", bready, 1);
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        chk("w2_rsp_valid", rsp_valid, 1);
        chk("w2_rsp_write", rsp_write, 1);
        chk("w2_single_b", bready, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("w2_rsp_done", rsp_valid, 0);

        // read 0x4, slave answers 0x12345678 with SLVERR
        arready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0004;
        step();
        cmd_valid = 1'b0;
        chk("r1_arvalid", arvalid, 1);
        chk("r1_araddr", araddr, 32'h0000_0004);
        chk("r1_no_awvalid", awvalid, 0);
        step();
        chk("r1_arvalid_drop", arvalid, 0);
        chk("r1_rready", rready, 1);
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10;
        step();
        rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        chk("r1_rsp_valid", rsp_valid, 1);
        chk("r1_rsp_write", rsp_write, 0);
        chk("r1_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("r1_rsp_resp", rsp_resp, 2'b10);
        chk("r1_rready_drop", rready, 0);

        // response back-pressure: 5 cycles with rsp_ready low, a new command waiting
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0008;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_no_arvalid", arvalid, 0);
            chk("bp_no_awvalid", awvalid, 0);
        end
        rsp_ready = 1'b1;
        chk("bp_cmd_ready_in_rsp", cmd_ready, 0);
        step();
        rsp_ready = 1'b0;
        chk("bp_rsp_done", rsp_valid, 0);
        chk("bp_cmd_ready_after", cmd_ready, 1);
        chk("bp_arvalid_not_yet", arvalid, 0);
        step();
        cmd_valid = 1'b0;
        chk("r2_arvalid", arvalid, 1);
        chk("r2_araddr", araddr, 32'h0000_0008);
        step();
        chk("r2_rready", rready, 1);
        rvalid = 1'b1; rdata = 32'hCAFE_0001; rresp = 2'b00;
        step();
        rvalid = 1'b0; rdata = '0;
        chk("r2_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
        chk("r2_rsp_resp", rsp_resp, 2'b00);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        arready = 1'b0;

        // reset asserted while waiting in WR_RESP
        awready = 1'b1; wready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0030; cmd_wdata = 32'h5555_AAAA;
        step();
        cmd_valid = 1'b0;
        step();
        chk("rs_bready_before", bready, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_bready_now", bready, 0);
        chk("rs_awvalid_now", awvalid, 0);
        chk("rs_wvalid_now", wvalid, 0);
        chk("rs_awaddr_now", awaddr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rs_no_rsp", rsp_valid, 0);
            chk("rs_cmd_ready", cmd_ready, 1);
        end
        bvalid = 1'b0;

`ifdef AXI_CTRL_MASTER_TIMEOUT_EN
        // watchdog: slave never answers B within 16 cycles of WR_RESP
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0040; cmd_wdata = 32'h0000_0001;
        step();
        cmd_valid = 1'b0;
        for (int c = 2; c <= 17; c++) begin
            step();
            chk("to_waiting", rsp_valid, 0);
        end
        step();
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_resp", rsp_resp, 2'b11);
        chk("to_rsp_write", rsp_write, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_bready_kept", bready, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("drain_no_rsp", rsp_valid, 0);
        chk("drain_cmd_ready", cmd_ready, 0);
        chk("drain_bready", bready, 1);
        step();
        chk("drain_cmd_ready_2", cmd_ready, 0);
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        chk("drain_bready_drop", bready, 0);
        chk("drain_cmd_ready_3", cmd_ready, 0);
        step();
        chk("drain_exit_idle", cmd_ready, 1);
        chk("drain_no_late_rsp", rsp_valid, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
